multiplication: RTL
===================

MULTIPLICATION -- requirements
Module: multiplication

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; product width is 2*WIDTH.
REQ-002 Port: clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin a multiply; sampled on a rising clock edge.
REQ-005 Port: a  input  WIDTH  unsigned multiplicand; sampled with start.
REQ-006 Port: b  input  WIDTH  unsigned multiplier; sampled with start.
REQ-007 Port: p  output  2*WIDTH  registered unsigned product a*b.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse marking p valid for the new result.

Function
REQ-010 The block SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-011 IDLE, start=1 at edge E0 -> latch a into multiplicand register, b into multiplier shift register, clear accumulator, load iteration counter with WIDTH, go to RUN, busy=1.
REQ-012 IDLE, start=0 -> stay in IDLE; all registers hold.
REQ-013 Each RUN edge SHALL perform one shift-add step:
  - if multiplier LSB=1, add multiplicand into the upper WIDTH bits of the accumulator, with carry-out kept (WIDTH+1-bit sum);
  - shift {carry, accumulator, multiplier} right by one;
  - decrement the counter.
REQ-014 The add SHALL be carry-preserving: no intermediate overflow for any operand pair.
REQ-015 At the edge where the counter reaches zero (edge E_WIDTH) -> load p with the 2*WIDTH-bit result, go to DONE, done=1, busy=0.
REQ-016 Latency: done SHALL be high during the cycle after edge E_WIDTH, exactly WIDTH cycles after the start-sampling edge.
REQ-017 DONE lasts exactly one cycle, then -> IDLE with done=0, unless start=1 in DONE.
REQ-018 start=1 in DONE SHALL be accepted as in REQ-011 (back-to-back): next state RUN, done=0 next cycle.
REQ-019 start during RUN SHALL be ignored; operands and progress remain unaffected.
REQ-020 p SHALL change only at REQ-015 edges or reset; it holds the previous product throughout RUN.
REQ-021 busy SHALL be 1 exactly in RUN; done exactly in DONE; never both high.
REQ-022 a and b changes after E0 SHALL have no effect on the running operation.
REQ-023 Operands of zero still take the full WIDTH cycles; there is no early termination.

Reset
REQ-024 reset=1 at a rising edge -> state IDLE, p=0, busy=0, done=0, accumulator/multiplier/counter cleared.
REQ-025 reset SHALL take priority over start and over any in-flight RUN step.
REQ-026 Reset mid-operation SHALL abandon the operation with no done pulse; the next start begins a fresh operation.
REQ-027 After reset deasserts, the first start is accepted on the first edge with reset=0.

Verification
REQ-028 a=3, b=5, start one cycle -> busy high 32 cycles; done pulse with p=15; p holds 15 afterwards.
REQ-029 a=b=0xFFFFFFFF -> p=0xFFFFFFFE00000001 at done; carry path exercised.
REQ-030 a=0, b=0x12345678 -> done after 32 cycles, p=0; a=0x80000000, b=2 -> p=0x0000000100000000.
REQ-031 Start 7x9, then toggle start and change a/b during RUN -> done only once, p=63; a second start in the DONE cycle with 6x7 -> next done 32 cycles later, p=42.
REQ-032 Start 11x13, assert reset at cycle 10 -> p=0, busy=0, no done; restart 11x13 -> p=143 after 32 cycles.

Source files
------------

// File: rtl/multiplication.sv
// Sequential shift-add unsigned multiplier.
//
// Performs one shift-add step per clock. A result is ready WIDTH cycles after
// start is sampled, and done pulses for one cycle when it is.
//
// Ports:
//   clock  - sole clock; all state changes on the rising edge
//   reset  - synchronous, active-high reset
//   start  - begin a multiply; accepted in IDLE or DONE, ignored in RUN
//   a, b   - unsigned operands, captured on the edge that accepts start
//   p      - registered 2*WIDTH-bit product; updated only when a result completes
//   busy   - high exactly while a multiply is running
//   done   - one-cycle pulse; p holds the new result during this cycle
module multiplication #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // One extra bit keeps the carry out of the partial-product add.
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   mplier_next;

    always_comb begin
        sum         = {1'b0, acc_q} + ({1'b0, mcand_q} & {(WIDTH + 1){mplier_q[0]}});
        // {carry, acc, mplier} shifted right by one bit.
        acc_next    = sum[WIDTH:1];
        mplier_next = {sum[0], mplier_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        busy_d   = busy_q;
        done_d   = done_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = CntW'(WIDTH);
                    state_d  = StRun;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                end
            end
            StRun: begin
                acc_d    = acc_next;
                mplier_d = mplier_next;
                cnt_d    = cnt_q - CntW'(1);
                // Last step: publish the freshly shifted result directly.
                if (cnt_q == CntW'(1)) begin
                    p_d     = {acc_next, mplier_next};
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                done_d = 1'b0;
                if (start) begin
                    // Back-to-back accept straight from the DONE cycle.
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = CntW'(WIDTH);
                    state_d  = StRun;
                    busy_d   = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign p    = p_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
